shift_right_jam_pipe: RTL and testbench

- Pipelined, multi-lane right shifter with sticky (jam) output for the FPU alignment and normalisation paths.
- Each lane shifts its own mantissa by its own amount and reports the OR of all bits shifted out.
- Operations move through DEPTH register stages under a valid/ready handshake with full backpressure.
- A tag travels alongside each operation and a flush kills everything in flight.

---
 rtl/shift_right_jam_pipe.sv | 180 ++++++++++++++++++
 tb/tb_shift_right_jam_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_jam_pipe.sv
// Pipelined multi-lane right shifter with sticky (jam) output and valid/ready backpressure.
// Optional: define SHIFT_RIGHT_JAM_PIPE_LSB_JAM_EN to fold each lane's sticky into its result LSB.
module shift_right_jam_pipe #(
  parameter int unsigned LEN   = 24,
  parameter int unsigned EXP   = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*LEN-1:0]   in_data,
  input  logic [LANES*EXP-1:0]   in_shamt,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LEN-1:0]   out_data,
  output logic [LANES-1:0]       out_sticky,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int unsigned LEVELS = $clog2(LEN + 1);
  localparam int unsigned BASE   = LEVELS / DEPTH;
  localparam int unsigned EXTRA  = LEVELS % DEPTH;
  localparam logic [EXP+31:0] LEN_WIDE = (EXP + 32)'(LEN);

  // Earlier stages absorb the remainder levels.
  function automatic int unsigned stage_lo(input int unsigned k);
    return k * BASE + ((k < EXTRA) ? k : EXTRA);
  endfunction

  function automatic int unsigned stage_hi(input int unsigned k);
    return stage_lo(k) + BASE + ((k < EXTRA) ? 1 : 0);
  endfunction

  // Low 2^j bits; wraps to all-ones when 2^j == LEN.
  function automatic logic [LEN-1:0] lvl_mask(input int unsigned j);
    return (LEN'(1) << (32'd1 << j)) - LEN'(1);
  endfunction

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;

  logic [LANES*LEN-1:0]        data_q     [DEPTH];
  logic [LANES-1:0]            sticky_q   [DEPTH];
  logic [LANES*LEVELS-1:0]     shamt_q    [DEPTH];
  logic [LANES-1:0]            exceed_q   [DEPTH];
  logic [TAG_W-1:0]            tag_q      [DEPTH];

  logic [LANES*LEN-1:0]        src_data   [DEPTH];
  logic [LANES-1:0]            src_sticky [DEPTH];
  logic [LANES*LEVELS-1:0]     src_shamt  [DEPTH];
  logic [LANES-1:0]            src_exceed [DEPTH];
  logic [TAG_W-1:0]            src_tag    [DEPTH];

  logic [LANES*LEN-1:0]        stage_data   [DEPTH];
  logic [LANES-1:0]            stage_sticky [DEPTH];

  // Ready chain: a stage may move if any later stage is empty or the output drains.
  always_comb begin
    logic open_chain;
    open_chain = out_ready;
    adv        = '0;
    load       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]     = valid_q[k] & open_chain;
      open_chain = open_chain | ~valid_q[k];
    end
    in_ready = open_chain;
    load[0]  = in_valid & open_chain;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
    end
  end

  // Stage sources: stage 0 pre-resolves the exceed case, later stages read the previous register.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      src_data[k]   = '0;
      src_sticky[k] = '0;
      src_shamt[k]  = '0;
      src_exceed[k] = '0;
      src_tag[k]    = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      logic [EXP-1:0] s;
      logic [LEN-1:0] d;
      logic           ex;
      s  = in_shamt[i*EXP +: EXP];
      d  = in_data[i*LEN +: LEN];
      ex = ({32'd0, s} > LEN_WIDE);
      src_data[0][i*LEN +: LEN]          = ex ? '0 : d;
      src_sticky[0][i]                   = ex & (|d);
      src_shamt[0][i*LEVELS +: LEVELS]   = LEVELS'(s);
      src_exceed[0][i]                   = ex;
    end
    src_tag[0] = in_tag;
    for (int k = 1; k < DEPTH; k++) begin
      src_data[k]   = data_q[k-1];
      src_sticky[k] = sticky_q[k-1];
      src_shamt[k]  = shamt_q[k-1];
      src_exceed[k] = exceed_q[k-1];
      src_tag[k]    = tag_q[k-1];
    end
  end

  // Each stage applies its slice of the binary shift levels and accumulates shifted-out bits.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stage_data[k]   = '0;
      stage_sticky[k] = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        logic [LEN-1:0]    d;
        logic              st;
        logic [LEVELS-1:0] sh;
        d  = src_data[k][i*LEN +: LEN];
        st = src_sticky[k][i];
        sh = src_shamt[k][i*LEVELS +: LEVELS];
        for (int unsigned j = 0; j < LEVELS; j++) begin
          if (j >= stage_lo(k) && j < stage_hi(k) && sh[j] && !src_exceed[k][i]) begin
            st = st | (|(d & lvl_mask(j)));
            d  = d >> (32'd1 << j);
          end
        end
        stage_data[k][i*LEN +: LEN] = d;
        stage_sticky[k][i]          = st;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k]   <= '0;
        sticky_q[k] <= '0;
        shamt_q[k]  <= '0;
        exceed_q[k] <= '0;
        tag_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else begin
          valid_q[k] <= load[k] | (valid_q[k] & ~adv[k]);
        end
        // Payload only moves on a load, so a stalled output stays put.
        if (load[k]) begin
          data_q[k]   <= stage_data[k];
          sticky_q[k] <= stage_sticky[k];
          shamt_q[k]  <= src_shamt[k];
          exceed_q[k] <= src_exceed[k];
          tag_q[k]    <= src_tag[k];
        end
      end
    end
  end

  always_comb begin
    out_valid  = valid_q[DEPTH-1];
    out_sticky = sticky_q[DEPTH-1];
    out_tag    = tag_q[DEPTH-1];
    out_data   = data_q[DEPTH-1];
`ifdef SHIFT_RIGHT_JAM_PIPE_LSB_JAM_EN
    for (int i = 0; i < LANES; i++) begin
      out_data[i*LEN] = data_q[DEPTH-1][i*LEN] | sticky_q[DEPTH-1][i];
    end
`endif
  end

  // The final stage's shift bookkeeping has no consumer.
  logic unused_last_stage;
  assign unused_last_stage = ^{shamt_q[DEPTH-1], exceed_q[DEPTH-1]};

endmodule

// File: tb/tb_shift_right_jam_pipe.sv
// Scoreboard bench for shift_right_jam_pipe: directed vectors, queued expectations, negedge monitor.
module tb_shift_right_jam_pipe;

  localparam int unsigned LEN   = 24;
  localparam int unsigned EXP   = 8;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*LEN-1:0] in_data;
  logic [LANES*EXP-1:0] in_shamt;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*LEN-1:0] out_data;
  logic [LANES-1:0]     out_sticky;
  logic [TAG_W-1:0]     out_tag;

  shift_right_jam_pipe #(
    .LEN   (LEN),
    .EXP   (EXP),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] d;
    logic [1:0]  s;
    logic [3:0]  t;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [47:0] jam(input logic [47:0] d, input logic [1:0] s);
    logic [47:0] r;
    r = d;
`ifdef SHIFT_RIGHT_JAM_PIPE_LSB_JAM_EN
    r[0]  = d[0] | s[0];
    r[24] = d[24] | s[1];
`endif
    return r;
  endfunction

  // Monitor: pop on every output handshake, and hold outputs steady across stalls.
  bit          hold_pending = 0;
  logic [47:0] held_d;
  logic [1:0]  held_s;
  logic [3:0]  held_t;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_stable", {out_data, out_sticky, out_tag}, {held_d, held_s, held_t});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {out_data, out_sticky, out_tag}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_sticky", 64'(out_sticky), 64'(e.s));
          check("out_tag", 64'(out_tag), 64'(e.t));
        end
      end
      hold_pending = out_valid && !out_ready && !flush;
      held_d = out_data;
      held_s = out_sticky;
      held_t = out_tag;
    end
  end

  task automatic send(input logic [47:0] d, input logic [15:0] s, input logic [3:0] tag,
                      input logic [47:0] ed, input logic [1:0] es, input bit track,
                      input bit toggle);
    bit acc;
    exp_t e;
    acc      = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_tag   = tag;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && track) begin
        e.d = jam(ed, es);
        e.s = es;
        e.t = tag;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input bit toggle);
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  logic [47:0] sd [10];
  logic [15:0] ss [10];
  logic [47:0] sed[10];
  logic [1:0]  ses[10];

  initial begin
    sd[0] = {24'hFFFFFF, 24'h123456}; ss[0] = {8'd23, 8'd4};
    sed[0] = {24'h000001, 24'h012345}; ses[0] = 2'b11;
    sd[1] = {24'h000010, 24'h000010}; ss[1] = {8'd5, 8'd4};
    sed[1] = {24'h000000, 24'h000001}; ses[1] = 2'b10;
    sd[2] = {24'h800000, 24'h800000}; ss[2] = {8'd24, 8'd23};
    sed[2] = {24'h000000, 24'h000001}; ses[2] = 2'b10;
    sd[3] = {24'h000002, 24'h000003}; ss[3] = {8'd1, 8'd1};
    sed[3] = {24'h000001, 24'h000001}; ses[3] = 2'b01;
    sd[4] = {24'h0F0F00, 24'hF0F0F0}; ss[4] = {8'd8, 8'd8};
    sed[4] = {24'h000F0F, 24'h00F0F0}; ses[4] = 2'b01;
    sd[5] = {24'hAAAAAA, 24'hFFFFFF}; ss[5] = {8'd16, 8'd25};
    sed[5] = {24'h0000AA, 24'h000000}; ses[5] = 2'b11;
    sd[6] = {24'h555555, 24'h400000}; ss[6] = {8'd2, 8'd22};
    sed[6] = {24'h155555, 24'h000001}; ses[6] = 2'b10;
    sd[7] = {24'h000080, 24'h000000}; ss[7] = {8'd7, 8'd0};
    sed[7] = {24'h000001, 24'h000000}; ses[7] = 2'b00;
    sd[8] = {24'h100001, 24'h100000}; ss[8] = {8'd20, 8'd20};
    sed[8] = {24'h000001, 24'h000001}; ses[8] = 2'b10;
    sd[9] = {24'h000001, 24'hC00000}; ss[9] = {8'd0, 8'd128};
    sed[9] = {24'h000001, 24'h000000}; ses[9] = 2'b01;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: result shows up exactly DEPTH cycles after the accepting cycle.
    send({24'h000100, 24'h800001}, {8'd8, 8'd1}, 4'h1,
         {24'h000001, 24'h400000}, 2'b01, 1, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      check("latency_valid", 64'(out_valid), 64'(k == DEPTH));
      if (k < DEPTH) begin
        @(posedge clk);
        #1;
      end
    end
    drain(0);

    send({24'h000001, 24'hABCDEF}, {8'd24, 8'd0}, 4'h2,
         {24'h000000, 24'hABCDEF}, 2'b10, 1, 0);
    send({24'h000000, 24'h7FFFFF}, {8'd255, 8'd200}, 4'h3,
         {24'h000000, 24'h000000}, 2'b01, 1, 0);
    drain(0);

    // Stream of 10 with out_ready toggling every cycle.
    for (int t = 0; t < 10; t++) begin
      send(sd[t], ss[t], 4'(t), sed[t], ses[t], 1, 1);
    end
    drain(1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fill the pipe under backpressure, then flush with a same-cycle input.
    out_ready = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      in_valid = 1'b1; in_data = sd[c]; in_shamt = ss[c]; in_tag = 4'(c + 8);
      @(posedge clk);
      #1;
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; in_tag = 4'hF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < DEPTH + 3; c++) begin
      @(posedge clk);
      #1;
      check("flush_quiet", 64'(out_valid), 64'd0);
    end

    // Flush drops an input even when in_ready is high.
    in_valid = 1'b1; in_data = sd[0]; in_shamt = ss[0]; in_tag = 4'hE; flush = 1'b1;
    #1;
    check("flush_empty_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < DEPTH + 3; c++) begin
      check("flush_drop", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    send({24'h000001, 24'hABCDEF}, {8'd24, 8'd0}, 4'h4,
         {24'h000000, 24'hABCDEF}, 2'b10, 1, 0);
    drain(0);

    // Asynchronous reset with two operations in flight.
    out_ready = 1'b0;
    send(sd[4], ss[4], 4'h5, sed[4], ses[4], 0, 0);
    send(sd[5], ss[5], 4'h6, sed[5], ses[5], 0, 0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", {out_data, out_sticky, out_tag}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    send({24'h000000, 24'h7FFFFF}, {8'd255, 8'd200}, 4'h7,
         {24'h000000, 24'h000000}, 2'b01, 1, 0);
    drain(0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
